// File: rtl/stump_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// stump_mem_arbiter_pkg
// Shared definitions for the Stump memory arbiter:
//   arb_state_t : arbitration FSM states (ARB = normal arbitration, LOCK = ext burst)
//   owner_t     : owner of a read in flight, used to steer returning memory data
//   cnt_width() : width of a counter that must hold the values 0..max_val
// -----------------------------------------------------------------------------
package stump_mem_arbiter_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CORE = 2'd1,
        OWNER_EXT  = 2'd2
    } owner_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stump_arb_fairness.sv
// -----------------------------------------------------------------------------
// stump_arb_fairness
// Starvation and lock-burst bookkeeping for the Stump memory arbiter.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   i_ext_gnt        ext port granted this cycle (any state)
//   i_ext_lost       contested cycle that the core won
//   i_core_gnt       core granted this cycle
//   i_lock_start     ext granted from ARB with ext_lock=1 (burst begins)
//   i_lock_gnt       ext granted while already in LOCK
//   o_starve_force   ext has lost STARVE_LIMIT contested cycles, it wins the next
//   o_lock_last      the current locked grant is the LOCK_MAX-th of the burst
//   o_core_force     burst ran out; core wins the next contested cycle
// -----------------------------------------------------------------------------
module stump_arb_fairness
    import stump_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ext_gnt,
    input  logic i_ext_lost,
    input  logic i_core_gnt,
    input  logic i_lock_start,
    input  logic i_lock_gnt,
    output logic o_starve_force,
    output logic o_lock_last,
    output logic o_core_force
);

    localparam int SW = cnt_width(STARVE_LIMIT);
    localparam int LW = cnt_width(LOCK_MAX);

    logic [SW-1:0] r_starve_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic          r_core_force;
    logic [LW-1:0] w_lock_inc;

    assign w_lock_inc     = r_lock_cnt + LW'(1);
    assign o_starve_force = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign o_core_force   = r_core_force;

    // The grant that opens a burst already counts as locked grant number one,
    // so with LOCK_MAX==1 the burst ends on that very grant.
    assign o_lock_last = i_lock_start ? (LOCK_MAX == 1)
                                      : (i_lock_gnt && (w_lock_inc == LW'(LOCK_MAX)));

    // Saturating count of contested cycles lost by ext; any ext grant clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (i_ext_gnt) begin
            r_starve_cnt <= '0;
        end else if (i_ext_lost && !o_starve_force) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_cnt <= '0;
        end else if (i_lock_start) begin
            r_lock_cnt <= LW'(1);
        end else if (i_lock_gnt) begin
            r_lock_cnt <= w_lock_inc;
        end
    end

    // Held until the core actually gets the bus, so an exhausted burst can
    // never be followed straight away by an ext win on starvation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_force <= 1'b0;
        end else if (o_lock_last) begin
            r_core_force <= 1'b1;
        end else if (i_core_gnt) begin
            r_core_force <= 1'b0;
        end
    end

endmodule

// File: rtl/stump_mem_arbiter.sv
// -----------------------------------------------------------------------------
// stump_mem_arbiter
// Shares the single-ported synchronous Stump memory between the Stump core and
// an external debug/DMA port. Core has priority; ext is protected from
// starvation and may lock the bus for bursts of up to LOCK_MAX grants.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   core_ren/wen/addr/wdata       core request (ren&wen together = write)
//   core_stall                    core request not granted this cycle
//   core_rdata                    core read data, valid cycle after grant
//   ext_req/we/lock/addr/wdata    ext request, held until ext_gnt
//   ext_gnt                       ext request consumed this cycle
//   ext_rvalid/ext_rdata          ext read return, cycle after grant
//   mem_ren/wen/addr/wdata        memory macro strobes and muxed address/data
//   mem_rdata                     memory read data, one cycle after mem_ren
// -----------------------------------------------------------------------------
module stump_mem_arbiter
    import stump_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_ren,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state, w_next_state;
    owner_t            r_owner_q, w_owner_d;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_ext_rdata;

    logic w_core_req;
    logic w_core_gnt;
    logic w_ext_gnt;
    logic w_ext_lost;
    logic w_lock_start;
    logic w_lock_gnt;
    logic w_starve_force;
    logic w_lock_last;
    logic w_core_force;

    assign w_core_req = core_ren | core_wen;

    stump_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .LOCK_MAX     (LOCK_MAX)
    ) u_fairness (
        .clk            (clk),
        .rst            (rst),
        .i_ext_gnt      (w_ext_gnt),
        .i_ext_lost     (w_ext_lost),
        .i_core_gnt     (w_core_gnt),
        .i_lock_start   (w_lock_start),
        .i_lock_gnt     (w_lock_gnt),
        .o_starve_force (w_starve_force),
        .o_lock_last    (w_lock_last),
        .o_core_force   (w_core_force)
    );

    // Grant decision. In ARB the core wins contested cycles unless ext has
    // starved, and an exhausted lock burst overrides starvation for one win.
    always_comb begin
        w_core_gnt = 1'b0;
        w_ext_gnt  = 1'b0;
        w_ext_lost = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_core_req && ext_req) begin
                    if (w_starve_force && !w_core_force) begin
                        w_ext_gnt = 1'b1;
                    end else begin
                        w_core_gnt = 1'b1;
                        w_ext_lost = 1'b1;
                    end
                end else if (w_core_req) begin
                    w_core_gnt = 1'b1;
                end else if (ext_req) begin
                    w_ext_gnt = 1'b1;
                end
            end
            ST_LOCK: begin
                w_ext_gnt = ext_req;
            end
            default: begin
                w_core_gnt = 1'b0;
            end
        endcase
    end

    assign w_lock_start = (r_state == ST_ARB)  && w_ext_gnt && ext_lock;
    assign w_lock_gnt   = (r_state == ST_LOCK) && w_ext_gnt;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_lock_start && !w_lock_last) begin
                    w_next_state = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (!ext_req || !ext_lock || w_lock_last) begin
                    w_next_state = ST_ARB;
                end
            end
            default: begin
                w_next_state = ST_ARB;
            end
        endcase
    end

    // Memory mux; a core request with both strobes is a write.
    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        w_owner_d = OWNER_NONE;
        if (w_core_gnt) begin
            mem_wen = core_wen;
            mem_ren = core_ren & ~core_wen;
            if (core_ren && !core_wen) begin
                w_owner_d = OWNER_CORE;
            end
        end else if (w_ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_we;
            mem_ren   = ~ext_we;
            if (!ext_we) begin
                w_owner_d = OWNER_EXT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_ARB;
            r_owner_q <= OWNER_NONE;
        end else begin
            r_state   <= w_next_state;
            r_owner_q <= w_owner_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_rdata <= '0;
            r_ext_rdata  <= '0;
        end else begin
            if (r_owner_q == OWNER_CORE) begin
                r_core_rdata <= mem_rdata;
            end
            if (r_owner_q == OWNER_EXT) begin
                r_ext_rdata <= mem_rdata;
            end
        end
    end

    // Returning data passes straight through in its return cycle so the
    // grant-to-data latency stays at one cycle; afterwards the copy holds it.
    assign core_rdata = (r_owner_q == OWNER_CORE) ? mem_rdata : r_core_rdata;
    assign ext_rdata  = (r_owner_q == OWNER_EXT)  ? mem_rdata : r_ext_rdata;
    assign ext_rvalid = (r_owner_q == OWNER_EXT);
    assign core_stall = w_core_req & ~w_core_gnt;
    assign ext_gnt    = w_ext_gnt;

    // Ext must hold its request until granted; there is no recovery logic.
    a_ext_req_held: assert property (
        @(posedge clk) disable iff (!rst) (ext_req && !w_ext_gnt) |=> ext_req
    );

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stump_mem_arbiter
// Self-checking bench for stump_mem_arbiter. Each cycle the bench drives both
// requesters together with the grant it expects, checks the combinational
// grant/stall/strobe outputs, and queues the read return it expects to see one
// cycle later. A small synchronous memory model stands in for the macro.
// -----------------------------------------------------------------------------
module tb_stump_mem_arbiter;

    localparam logic [1:0] SB_NONE = 2'd0;
    localparam logic [1:0] SB_CORE = 2'd1;
    localparam logic [1:0] SB_EXT  = 2'd2;

    logic        clk;
    logic        rst;
    logic        core_ren;
    logic        core_wen;
    logic [15:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_stall;
    logic [15:0] core_rdata;
    logic        ext_req;
    logic        ext_we;
    logic        ext_lock;
    logic [15:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [15:0] ext_rdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    typedef struct {
        logic [1:0]  owner;
        logic [15:0] data;
    } sbEntry_t;

    sbEntry_t    sb[$];
    logic [15:0] macroMem[256];
    logic [15:0] refMem[256];
    int          checkCount = 0;
    int          errorCount = 0;

    stump_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_ren   (core_ren),
        .core_wen   (core_wen),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_lock   (ext_lock),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro model; reloaded with its known contents while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            macroMem[8'h10] <= 16'hBEEF;
            macroMem[8'h20] <= 16'hCAFE;
        end else begin
            if (mem_wen) macroMem[mem_addr[7:0]] <= mem_wdata;
            if (mem_ren) mem_rdata <= macroMem[mem_addr[7:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic printSummary();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    endtask

    task automatic driveIdle();
        core_ren   = 1'b0;
        core_wen   = 1'b0;
        core_addr  = 16'h0;
        core_wdata = 16'h0;
        ext_req    = 1'b0;
        ext_we     = 1'b0;
        ext_lock   = 1'b0;
        ext_addr   = 16'h0;
        ext_wdata  = 16'h0;
    endtask

    // One bus cycle: check the return owed from last cycle, drive new
    // requests, check the grant outcome, queue the return this grant owes.
    task automatic applyStimulus(input logic cRen, input logic cWen,
                                 input logic [15:0] cAddr, input logic [15:0] cWdata,
                                 input logic eReq, input logic eWe, input logic eLock,
                                 input logic [15:0] eAddr, input logic [15:0] eWdata,
                                 input logic expCore, input logic expExt, input string tag);
        sbEntry_t    e;
        logic        expRen;
        logic        expWen;
        logic [15:0] expAddr;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "/ext_rvalid"}, 32'(ext_rvalid), 32'(e.owner == SB_EXT));
            if (e.owner == SB_CORE) checkOutput({tag, "/core_rdata"}, 32'(core_rdata), 32'(e.data));
            if (e.owner == SB_EXT)  checkOutput({tag, "/ext_rdata"}, 32'(ext_rdata), 32'(e.data));
        end
        core_ren   = cRen;
        core_wen   = cWen;
        core_addr  = cAddr;
        core_wdata = cWdata;
        ext_req    = eReq;
        ext_we     = eWe;
        ext_lock   = eLock;
        ext_addr   = eAddr;
        ext_wdata  = eWdata;
        #1;
        expRen  = expCore ? (cRen & ~cWen) : (expExt ? ~eWe : 1'b0);
        expWen  = expCore ? cWen : (expExt ? eWe : 1'b0);
        expAddr = expCore ? cAddr : eAddr;
        checkOutput({tag, "/core_stall"}, 32'(core_stall), 32'((cRen | cWen) & ~expCore));
        checkOutput({tag, "/ext_gnt"}, 32'(ext_gnt), 32'(expExt));
        checkOutput({tag, "/strobes"}, 32'({mem_ren, mem_wen}), 32'({expRen, expWen}));
        if (expCore || expExt) checkOutput({tag, "/mem_addr"}, 32'(mem_addr), 32'(expAddr));
        if (expWen) checkOutput({tag, "/mem_wdata"}, 32'(mem_wdata), 32'(expCore ? cWdata : eWdata));
        e.owner = SB_NONE;
        e.data  = 16'h0;
        if (expCore && cRen && !cWen) begin
            e.owner = SB_CORE;
            e.data  = refMem[cAddr[7:0]];
        end else if (expExt && !eWe) begin
            e.owner = SB_EXT;
            e.data  = refMem[eAddr[7:0]];
        end
        sb.push_back(e);
        if (expCore && cWen) refMem[cAddr[7:0]] = cWdata;
        if (expExt && eWe)   refMem[eAddr[7:0]] = eWdata;
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        #200000;
        errorCount++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        printSummary();
        $finish;
    end

    initial begin
        string       pat;
        int          extIdx;
        logic [15:0] eAddr;
        logic [15:0] eData;
        logic        eReq;

        refMem[8'h10] = 16'hBEEF;
        refMem[8'h20] = 16'hCAFE;
        rst = 1'b0;
        driveIdle();
        repeat (2) @(negedge clk);
        checkOutput("reset/core_stall", 32'(core_stall), 32'(0));
        checkOutput("reset/ext_rvalid", 32'(ext_rvalid), 32'(0));
        checkOutput("reset/core_rdata", 32'(core_rdata), 32'(0));
        checkOutput("reset/ext_rdata", 32'(ext_rdata), 32'(0));
        checkOutput("reset/strobes", 32'({mem_ren, mem_wen}), 32'(0));
        rst = 1'b1;

        // Reset landing while a core read is in flight.
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "rstCore");
        @(posedge clk);
        #2;
        driveIdle();
        rst = 1'b0;
        #1;
        checkOutput("rstCore/core_rdata", 32'(core_rdata), 32'(0));
        checkOutput("rstCore/ext_rvalid", 32'(ext_rvalid), 32'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b1;

        // Reset landing while an ext read is in flight.
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b1, "rstExt");
        @(posedge clk);
        #2;
        driveIdle();
        rst = 1'b0;
        #1;
        checkOutput("rstExt/ext_rvalid", 32'(ext_rvalid), 32'(0));
        checkOutput("rstExt/ext_rdata", 32'(ext_rdata), 32'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        idleCycles(3, "postReset");

        // Core alone.
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "coreAlone");
        idleCycles(1, "coreAlone");

        // Contention: ext loses four contested cycles, wins the fifth.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0,
                          1'(i < 4), 1'(i == 4), "contend");
        end
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "contend");
        idleCycles(1, "contend");

        // Locked ext writes 0x30..0x3B against a waiting core. C = core
        // granted, E = ext granted, - = nobody granted (LOCK, ext idle).
        pat    = "CCCCEEEEEEEECCCCEEEE-C";
        extIdx = 0;
        for (int i = 0; i < pat.len(); i++) begin
            eReq  = (extIdx < 12);
            eAddr = 16'h0030 + 16'(extIdx);
            eData = 16'hA000 + 16'(extIdx);
            applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, eReq, eReq, eReq, eAddr, eData,
                          1'(pat[i] == "C"), 1'(pat[i] == "E"), "lock");
            if (pat[i] == "E") extIdx++;
        end
        idleCycles(1, "lock");
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "lockRead");
        applyStimulus(1'b1, 1'b0, 16'h0037, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "lockRead");
        applyStimulus(1'b1, 1'b0, 16'h003B, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "lockRead");
        idleCycles(1, "lockRead");

        // Lock release by ext_lock=0 on the fourth grant.
        applyStimulus(1'b0, 1'b0, 16'h0,    16'h0, 1'b1, 1'b1, 1'b1, 16'h0050, 16'h5050, 1'b0, 1'b1, "release");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0051, 16'h5151, 1'b0, 1'b1, "release");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0052, 16'h5252, 1'b0, 1'b1, "release");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0053, 16'h5353, 1'b0, 1'b1, "release");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0054, 16'h5454, 1'b1, 1'b0, "release");
        applyStimulus(1'b0, 1'b0, 16'h0,    16'h0, 1'b1, 1'b1, 1'b0, 16'h0054, 16'h5454, 1'b0, 1'b1, "release");
        applyStimulus(1'b0, 1'b0, 16'h0,    16'h0, 1'b1, 1'b0, 1'b0, 16'h0053, 16'h0,    1'b0, 1'b1, "releaseRead");
        idleCycles(1, "releaseRead");

        // Both core strobes high is a write.
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "bothStrobes");
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0,    1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, "bothStrobes");
        idleCycles(2, "tail");

        printSummary();
        $finish;
    end

endmodule
